// File: rtl/aes_dma_pkg.sv
// ----------------------------------------------------------------------------
// aes_dma_pkg
// Shared types and constants for the AES block DMA initiator.
//   state_t          : FSM state encoding of ahb_block_master
//   HTRANS_*         : AHB transfer type codes used by the initiator
//   HSIZE_WORD       : 32-bit transfer size code
//   WORDS_PER_BLOCK  : 32-bit words in one 128-bit AES block
//   BYTES_PER_WORD   : byte stride between consecutive beats
// ----------------------------------------------------------------------------
package aes_dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_BLK_RDY,
        ST_WAIT_AES,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam int         WORDS_PER_BLOCK = 4;
    localparam int         BYTES_PER_WORD  = 4;

endpackage

// File: rtl/ahb_block_master_if.sv
// ----------------------------------------------------------------------------
// ahb_block_master_if
// AHB-Lite signal bundle between the block master and the system bus.
//   haddr/htrans/hwrite/hsize/hwdata : driven by the initiator
//   hrdata/hready/hresp              : driven by the addressed slave
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface ahb_block_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/beat_counter.sv
// ----------------------------------------------------------------------------
// beat_counter
// Byte pointer plus 2-bit word-within-block index for one side (read or
// write) of the block master.
//   clk, n_rst   : clock, async active-low reset
//   i_load       : load i_load_addr into the pointer, clear the index
//   i_load_addr  : start byte address of the region
//   i_inc        : one beat completed; pointer += 4, index += 1
//   o_ptr        : current byte address
//   o_idx        : word index inside the current block
//   o_last       : current beat is the final word of the block
// ----------------------------------------------------------------------------
module beat_counter
    import aes_dma_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_addr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr,
    output logic [1:0]   o_idx,
    output logic         o_last
);

    logic [W-1:0] r_ptr;
    logic [1:0]   r_idx;

    // The 2-bit index wraps by itself after the fourth beat, so no reload is
    // needed between blocks; the pointer wraps modulo 2^W.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_addr;
            r_idx <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(BYTES_PER_WORD);
            r_idx <= r_idx + 2'd1;
        end
    end

    assign o_ptr  = r_ptr;
    assign o_idx  = r_idx;
    assign o_last = (r_idx == 2'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/ahb_block_master.sv
// ----------------------------------------------------------------------------
// ahb_block_master
// AHB-Lite initiator moving 128-bit AES blocks: reads four words from the
// source region into rx_sr, waits for the AES core, writes four words from
// tx_sr to the destination region, repeated for size_data[31:4] blocks.
//   clk, n_rst          : clock, async active-low reset
//   start               : one-cycle request, sampled in IDLE only
//   src_addr, dst_addr  : word-aligned region start addresses
//   size_data           : region size in bytes (low 4 bits ignored)
//   bus                 : AHB-Lite master modport
//   rx_word/rx_shift_en : word and shift strobe towards rx_sr
//   tx_word/tx_shift_en : head word of tx_sr and advance strobe
//   block_ready         : pulse, full block shifted into rx_sr
//   last_block          : final block of the region in flight
//   aes_done            : AES result available in tx_sr
//   busy, done, error   : status (error is sticky until next start)
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for start
// ST_RD_ADDR  | read address phase (NONSEQ) at rd pointer
// ST_RD_DATA  | read data phase, shift word into rx_sr on completion
// ST_BLK_RDY  | one-cycle block_ready pulse
// ST_WAIT_AES | waiting for aes_done
// ST_WR_ADDR  | write address phase (NONSEQ) at wr pointer
// ST_WR_DATA  | write data phase, advance tx_sr on completion
// ST_NEXT     | block finished, decrement block count
// ST_DONE     | one-cycle done pulse
// ST_ERR      | bus error seen, back to IDLE next cycle
// ----------------------------------------------------------------------------
module ahb_block_master
    import aes_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [31:0]          size_data,
    ahb_block_master_if.master   bus,
    output logic [DATA_W-1:0]    rx_word,
    output logic                 rx_shift_en,
    input  logic [DATA_W-1:0]    tx_word,
    output logic                 tx_shift_en,
    output logic                 block_ready,
    output logic                 last_block,
    input  logic                 aes_done,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_t            r_state;
    state_t            w_next;
    logic [27:0]       r_blk_cnt;
    logic              r_error;

    logic              w_start_ok;
    logic              w_rd_beat;
    logic              w_wr_beat;
    logic              w_bus_err;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [1:0]        w_rd_idx;
    logic [1:0]        w_wr_idx;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [27:0]       w_blocks;
    logic              w_unused;

    assign w_blocks   = size_data[31:4];
    assign w_unused   = ^{size_data[3:0], w_rd_idx, w_wr_idx};

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_rd_beat  = (r_state == ST_RD_DATA) && bus.hready && !bus.hresp;
    assign w_wr_beat  = (r_state == ST_WR_DATA) && bus.hready && !bus.hresp;
    assign w_bus_err  = ((r_state == ST_RD_DATA) || (r_state == ST_WR_DATA)) && bus.hresp;

    beat_counter #(.W(ADDR_W)) u_rd_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_load      (w_start_ok),
        .i_load_addr (src_addr),
        .i_inc       (w_rd_beat),
        .o_ptr       (w_rd_ptr),
        .o_idx       (w_rd_idx),
        .o_last      (w_rd_last)
    );

    beat_counter #(.W(ADDR_W)) u_wr_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_load      (w_start_ok),
        .i_load_addr (dst_addr),
        .i_inc       (w_wr_beat),
        .o_ptr       (w_wr_ptr),
        .o_idx       (w_wr_idx),
        .o_last      (w_wr_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_blk_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_blk_cnt <= w_blocks;
                r_error   <= 1'b0;
            end else if (r_state == ST_NEXT) begin
                r_blk_cnt <= r_blk_cnt - 28'd1;
            end
            if (w_bus_err) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_blocks == 28'd0) ? ST_DONE : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (bus.hready) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // An error response wins even on its first (hready=0) cycle.
                if (bus.hresp)       w_next = ST_ERR;
                else if (bus.hready) w_next = w_rd_last ? ST_BLK_RDY : ST_RD_ADDR;
            end
            ST_BLK_RDY:  w_next = ST_WAIT_AES;
            ST_WAIT_AES: begin
                if (aes_done) w_next = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (bus.hready) w_next = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (bus.hresp)       w_next = ST_ERR;
                else if (bus.hready) w_next = w_wr_last ? ST_NEXT : ST_WR_ADDR;
            end
            ST_NEXT:  w_next = (r_blk_cnt == 28'd1) ? ST_DONE : ST_RD_ADDR;
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the state register; haddr is zero outside
    // address phases so an async reset drops the bus to a clean IDLE.
    always_comb begin
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.haddr  = '0;
        bus.hwdata = '0;
        case (r_state)
            ST_RD_ADDR: begin
                bus.htrans = HTRANS_NONSEQ;
                bus.haddr  = w_rd_ptr;
            end
            ST_WR_ADDR: begin
                bus.htrans = HTRANS_NONSEQ;
                bus.hwrite = 1'b1;
                bus.haddr  = w_wr_ptr;
            end
            ST_WR_DATA: begin
                bus.hwdata = tx_word;
            end
            default: begin
            end
        endcase
    end

    assign bus.hsize   = HSIZE_WORD;

    assign rx_word     = bus.hrdata;
    assign rx_shift_en = w_rd_beat;
    assign tx_shift_en = w_wr_beat;
    assign block_ready = (r_state == ST_BLK_RDY);
    assign done        = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign error       = r_error;
    assign last_block  = busy && (r_blk_cnt == 28'd1) &&
                         (r_state != ST_DONE) && (r_state != ST_ERR);

endmodule

// File: tb/tb_ahb_block_master.sv
module tb_ahb_block_master;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [31:0] src_addr, dst_addr, size_data;
    logic [31:0] rx_word, tx_word;
    logic        rx_shift_en, tx_shift_en, block_ready, last_block;
    logic        aes_done, busy, done, error;

    always #5 clk = ~clk;

    ahb_block_master_if bus ();

    ahb_block_master dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .size_data   (size_data),
        .bus         (bus),
        .rx_word     (rx_word),
        .rx_shift_en (rx_shift_en),
        .tx_word     (tx_word),
        .tx_shift_en (tx_shift_en),
        .block_ready (block_ready),
        .last_block  (last_block),
        .aes_done    (aes_done),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference environment state ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] seed;
    logic [31:0] aes_out [$];
    logic [31:0] txq [$];
    int          wait_states = 0;
    int          aes_lat     = 1;
    int          err_beat    = -1;
    bit          inject_aes  = 0;
    int          injected_cnt;

    // logs of what the DUT did
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rx_q      [$];
    int          rd_cyc_q  [$];
    int nonseq_cnt, br_cnt, done_cnt, done_cyc, lb_first, lb_cnt, start_cyc;
    int rd_beats, blk_loaded;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        rx_q.delete(); rd_cyc_q.delete(); txq.delete();
        nonseq_cnt = 0; br_cnt = 0; done_cnt = 0; done_cyc = -1;
        lb_first = -1; lb_cnt = 0; rd_beats = 0; blk_loaded = 0; injected_cnt = 0;
    endtask

    // Slave memory, AES core and tx_sr model plus activity monitor.
    bit          dp_active = 0, dp_write = 0, dp_done, addr_phase, pop_pending = 0;
    logic [31:0] dp_addr;
    int          dp_wait = 0, aes_cnt = 0;
    logic [31:0] dummy;

    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                dp_active = 0; aes_cnt = 0; pop_pending = 0; txq.delete();
                bus.hready = 1'b1; bus.hresp = 1'b0; aes_done = 1'b0; tx_word = '0;
            end else begin
                if (pop_pending) begin
                    if (txq.size() > 0) dummy = txq.pop_front();
                    pop_pending = 0;
                end
                aes_done = 1'b0;
                if (aes_cnt > 0) begin
                    aes_cnt--;
                    if (aes_cnt == 0) begin
                        aes_done = 1'b1;
                        for (int i = 0; i < 4; i++)
                            txq.push_back((blk_loaded*4+i < aes_out.size()) ? aes_out[blk_loaded*4+i] : 32'h0);
                        blk_loaded++;
                    end
                end
                if (block_ready) aes_cnt = aes_lat;
                tx_word = (txq.size() > 0) ? txq[0] : 32'h0;
                if (inject_aes && dp_active && !dp_write) begin
                    aes_done = 1'b1; inject_aes = 0; injected_cnt++;
                end
                bus.hready = 1'b1; bus.hresp = 1'b0; dp_done = 0;
                if (dp_active) begin
                    if (dp_wait > 0) begin
                        bus.hready = 1'b0; dp_wait--;
                    end else begin
                        if (!dp_write) begin
                            bus.hrdata = mem_rd(dp_addr);
                            if (rd_beats == err_beat) bus.hresp = 1'b1;
                            rd_beats++;
                        end
                        dp_done = 1;
                    end
                end
                addr_phase = (bus.htrans == 2'b10);
                #1;
                if (addr_phase) begin
                    nonseq_cnt++;
                    if (bus.hwrite) wr_addr_q.push_back(bus.haddr);
                    else begin rd_addr_q.push_back(bus.haddr); rd_cyc_q.push_back(cyc); end
                end
                if (dp_done && dp_write) wr_data_q.push_back(bus.hwdata);
                if (rx_shift_en) rx_q.push_back(rx_word);
                if (tx_shift_en) pop_pending = 1;
                if (block_ready) br_cnt++;
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (last_block) begin
                    if (lb_cnt == 0) lb_first = cyc;
                    lb_cnt++;
                end
                if (dp_done) dp_active = 0;
                if (addr_phase && bus.hready) begin
                    dp_active = 1; dp_write = bus.hwrite; dp_addr = bus.haddr; dp_wait = wait_states;
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
        @(negedge clk);
        src_addr = s; dst_addr = d; size_data = z; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        #2;
        while (busy && n < 3000) begin
            @(negedge clk); #2; n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Expected behaviour of a fully completed region, derived from the
    // address/data rules and the per-phase cycle costs.
    task automatic check_full(input string t, input logic [31:0] s, input logic [31:0] d,
                              input int nblk, input int ws, input int lat);
        int per, k;
        per = 2 * 4 * (2 + ws) + 2 + lat;
        check({t, ":n_rd"},   32'(rd_addr_q.size()), 32'(4*nblk));
        check({t, ":n_wr"},   32'(wr_addr_q.size()), 32'(4*nblk));
        check({t, ":n_wdat"}, 32'(wr_data_q.size()), 32'(4*nblk));
        check({t, ":n_rx"},   32'(rx_q.size()),      32'(4*nblk));
        for (int i = 0; i < rd_addr_q.size(); i++) check({t, ":rd_addr"}, rd_addr_q[i], s + 32'(4*i));
        for (int i = 0; i < rx_q.size(); i++)      check({t, ":rx_word"}, rx_q[i], mem_rd(s + 32'(4*i)));
        for (int i = 0; i < wr_addr_q.size(); i++) check({t, ":wr_addr"}, wr_addr_q[i], d + 32'(4*i));
        for (int i = 0; i < wr_data_q.size() && i < aes_out.size(); i++)
            check({t, ":wr_data"}, wr_data_q[i], aes_out[i]);
        check({t, ":blk_rdy"}, 32'(br_cnt), 32'(nblk));
        check({t, ":done_cnt"}, 32'(done_cnt), 32'd1);
        check({t, ":error"}, 32'(error), 32'd0);
        check({t, ":latency"}, 32'(done_cyc - start_cyc), 32'(1 + nblk*per));
        check({t, ":first_nonseq"}, 32'((rd_cyc_q.size() > 0) ? rd_cyc_q[0] - start_cyc : -1), 32'd1);
        k = 4 * (nblk - 1);
        check({t, ":lb_first"}, 32'(lb_first), 32'((rd_cyc_q.size() > k) ? rd_cyc_q[k] : -1));
        check({t, ":lb_len"}, 32'(lb_cnt), 32'(done_cyc - lb_first));
    endtask

    logic [31:0] s, d;
    int          n;

    initial begin
        start = 0; src_addr = 0; dst_addr = 0; size_data = 0; aes_done = 0; tx_word = 0;
        bus.hrdata = 0; bus.hready = 1; bus.hresp = 0;
        seed  = $urandom;
        n_rst = 1'b0;
        clear_logs();
        #12;
        check("rst:haddr",  bus.haddr, 32'h0);
        check("rst:htrans", 32'(bus.htrans), 32'd0);
        check("rst:hwrite", 32'(bus.hwrite), 32'd0);
        check("rst:hsize",  32'(bus.hsize), 32'd2);
        check("rst:hwdata", bus.hwdata, 32'h0);
        check("rst:flags",  32'({busy, done, error, block_ready, last_block, rx_shift_en, tx_shift_en}), 32'd0);
        @(posedge clk); #3 n_rst = 1'b1;

        // single block, directed data
        mem[32'h100] = 32'habcd52c2; mem[32'h104] = 32'hf9c6f303;
        mem[32'h108] = 32'h030f8303; mem[32'h10C] = 32'h1ab61040;
        aes_out = {32'hEC91CEF5, 32'h476D5AAC, 32'h828007DB, 32'hB58A1B20};
        wait_states = 0; aes_lat = 1; err_beat = -1;
        clear_logs();
        pulse_start(32'h100, 32'h200, 32'd16);
        wait_idle("t1:timeout");
        check_full("t1", 32'h100, 32'h200, 1, 0, 1);

        // three blocks with one wait state per data phase, src wraps past 2^32
        aes_out.delete();
        for (int i = 0; i < 12; i++) aes_out.push_back($urandom);
        wait_states = 1; aes_lat = 2;
        s = 32'hFFFF_FFE0; d = $urandom & 32'hFFFF_FFFC;
        clear_logs();
        pulse_start(s, d, 32'd48 | 32'($urandom_range(0, 15)));
        wait_idle("t2:timeout");
        check_full("t2", s, d, 3, 1, 2);
        check("t2:period", 32'((rd_cyc_q.size() > 4) ? rd_cyc_q[4] - rd_cyc_q[0] : -1), 32'd28);

        // zero-block regions
        wait_states = 0; aes_lat = 1;
        for (int z = 0; z < 2; z++) begin
            clear_logs();
            pulse_start($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, (z == 0) ? 32'd0 : 32'd15);
            wait_idle("zero:timeout");
            check("zero:latency", 32'(done_cyc - start_cyc), 32'd1);
            check("zero:nonseq", 32'(nonseq_cnt), 32'd0);
            check("zero:done_cnt", 32'(done_cnt), 32'd1);
        end

        // bus error on third read of block 2
        aes_out.delete();
        for (int i = 0; i < 8; i++) aes_out.push_back($urandom);
        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
        aes_lat = 3; err_beat = 6;
        clear_logs();
        pulse_start(s, d, 32'd32);
        wait_idle("err:timeout");
        err_beat = -1;
        check("err:error", 32'(error), 32'd1);
        check("err:n_rx", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < rx_q.size(); i++) check("err:rx_word", rx_q[i], mem_rd(s + 32'(4*i)));
        check("err:n_wr", 32'(wr_addr_q.size()), 32'd4);
        check("err:nonseq", 32'(nonseq_cnt), 32'd11);
        check("err:done_cnt", 32'(done_cnt), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("err:nonseq_after", 32'(nonseq_cnt), 32'd11);
        check("err:sticky", 32'(error), 32'd1);
        aes_lat = 1;
        clear_logs();
        pulse_start(s, d, 32'd16);
        #2;
        check("err:cleared", 32'(error), 32'd0);
        wait_idle("err2:timeout");
        check_full("err2", s, d, 1, 0, 1);

        // reset during a write data phase
        clear_logs();
        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
        pulse_start(s, d, 32'd16);
        n = 0;
        while (wr_addr_q.size() == 0 && n < 500) begin @(negedge clk); #2; n++; end
        check("rst2:reach_wr", 32'(wr_addr_q.size()), 32'd1);
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check("rst2:htrans", 32'(bus.htrans), 32'd0);
        check("rst2:busy", 32'(busy), 32'd0);
        check("rst2:haddr", bus.haddr, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 n_rst = 1'b1;
        clear_logs();
        pulse_start(s, d, 32'd16);
        wait_idle("rst3:timeout");
        check_full("rst3", s, d, 1, 0, 1);

        // start while busy and stray aes_done during a read data phase
        clear_logs();
        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
        pulse_start(s, d, 32'd32);
        repeat (2) @(negedge clk);
        start = 1'b1; src_addr = ~s; dst_addr = ~d; size_data = 32'd0; inject_aes = 1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ign:timeout");
        check_full("ign", s, d, 2, 0, 1);
        check("ign:injected", 32'(injected_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
